// File: rtl/alu_iter_pkg.sv
// Shared defaults, action codes and FSM encoding for alu_iter.
// The divider is present only when ALU_ITER_DIV_EN is defined.
package alu_iter_pkg;

  localparam int WIDTH_DEF       = 16;
  localparam int ACTION_BITS_DEF = 4;

  localparam int ACT_ADD  = 0;
  localparam int ACT_SUB  = 1;
  localparam int ACT_AND  = 2;
  localparam int ACT_OR   = 3;
  localparam int ACT_NOT  = 4;
  localparam int ACT_NEG  = 5;
  localparam int ACT_SHL  = 6;
  localparam int ACT_SHR  = 7;
  localparam int ACT_HIB  = 8;
  localparam int ACT_PASS = 9;
  localparam int ACT_MUL  = 10;
  localparam int ACT_DIVU = 11;
  localparam int ACT_SRA  = 12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_iter_core.sv
// Iterative datapath: shift-add signed multiply (on magnitudes) and, when
// ALU_ITER_DIV_EN is defined, restoring unsigned divide; WIDTH iterations per op.
module alu_iter_core
  import alu_iter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             is_mul_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] hi_o
);

  localparam int CW = $clog2(WIDTH);

  logic               busy_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   hi_q, lo_q, dvs_q;
  logic               neg_q;
  logic               mul_q;
  logic               load_s;
  logic [WIDTH-1:0]   a_mag_s, b_mag_s;
  logic [WIDTH:0]     sum_s;
  logic [WIDTH-1:0]   mul_hi_s, mul_lo_s, div_hi_s, div_lo_s;
  logic [WIDTH-1:0]   hi_d, lo_d;
  logic [2*WIDTH-1:0] mag_s, prod_s;

`ifdef ALU_ITER_DIV_EN
  logic [WIDTH:0]     shift_s, trial_s;

  assign load_s = start_i;

  // Remember which operation owns the shared registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      mul_q <= 1'b0;
    end else if (load_s) begin
      mul_q <= is_mul_i;
    end else begin
      mul_q <= mul_q;
    end
  end

  // One restoring-divide step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    shift_s  = {hi_q, lo_q[WIDTH-1]};
    trial_s  = shift_s - {1'b0, dvs_q};
    div_hi_s = trial_s[WIDTH] ? shift_s[WIDTH-1:0] : trial_s[WIDTH-1:0];
    div_lo_s = {lo_q[WIDTH-2:0], ~trial_s[WIDTH]};
  end
`else
  // Only multiply exists in this build; other multi-cycle codes never start it.
  assign load_s   = start_i & is_mul_i;
  assign mul_q    = 1'b1;
  assign div_hi_s = {WIDTH{1'b0}};
  assign div_lo_s = {WIDTH{1'b0}};
`endif

  assign a_mag_s = a_i[WIDTH-1] ? ({WIDTH{1'b0}} - a_i) : a_i;
  assign b_mag_s = b_i[WIDTH-1] ? ({WIDTH{1'b0}} - b_i) : b_i;
  assign done_o  = busy_q && (cnt_q == CW'(WIDTH - 1));

  // One shift-add step on {hi,lo}, then pick the step for the active op and sign-fix the product.
  always_comb begin
    sum_s    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, dvs_q} : {(WIDTH+1){1'b0}});
    mul_hi_s = sum_s[WIDTH:1];
    mul_lo_s = {sum_s[0], lo_q[WIDTH-1:1]};
    hi_d     = mul_q ? mul_hi_s : div_hi_s;
    lo_d     = mul_q ? mul_lo_s : div_lo_s;
    mag_s    = {hi_d, lo_d};
    prod_s   = neg_q ? ({(2*WIDTH){1'b0}} - mag_s) : mag_s;
    lo_o     = mul_q ? prod_s[WIDTH-1:0] : lo_d;
    hi_o     = mul_q ? prod_s[2*WIDTH-1:WIDTH] : hi_d;
  end

  // Operand load on start, then one iteration per cycle until the last count.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      busy_q <= 1'b0;
      cnt_q  <= {CW{1'b0}};
      hi_q   <= {WIDTH{1'b0}};
      lo_q   <= {WIDTH{1'b0}};
      dvs_q  <= {WIDTH{1'b0}};
      neg_q  <= 1'b0;
    end else if (load_s) begin
      busy_q <= 1'b1;
      cnt_q  <= {CW{1'b0}};
      hi_q   <= {WIDTH{1'b0}};
      lo_q   <= is_mul_i ? b_mag_s : a_i;
      dvs_q  <= is_mul_i ? a_mag_s : b_i;
      neg_q  <= is_mul_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
    end else if (busy_q) begin
      busy_q <= ~done_o;
      cnt_q  <= cnt_q + CW'(1);
      hi_q   <= hi_d;
      lo_q   <= lo_d;
    end else begin
      busy_q <= busy_q;
    end
  end

endmodule

// File: rtl/alu_iter.sv
// Registered ALU with valid/ready request port: single-cycle ops in place,
// MUL (and DIVU when ALU_ITER_DIV_EN is defined) via alu_iter_core.
module alu_iter
  import alu_iter_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEF,
  parameter int ACTION_BITS = ACTION_BITS_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ACTION_BITS-1:0] alu_action,
  input  logic [WIDTH-1:0]       A,
  input  logic [WIDTH-1:0]       B,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       result,
  output logic [WIDTH-1:0]       result_hi,
  output logic                   div0
);

  state_t           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] result_hi_q, result_hi_d;
  logic             div0_q, div0_d;
  logic             pend_div0_q, pend_div0_d;
  logic             accept_s, is_mul_s, is_div_s, multi_s, start_s;
  logic             core_done_s;
  logic [WIDTH-1:0] core_lo_s, core_hi_s, single_s;

  assign in_ready  = (state_q != ST_BUSY);
  assign accept_s  = in_valid && in_ready;
  assign is_mul_s  = (alu_action == ACTION_BITS'(ACT_MUL));
`ifdef ALU_ITER_DIV_EN
  assign is_div_s  = (alu_action == ACTION_BITS'(ACT_DIVU));
`else
  assign is_div_s  = 1'b0;
`endif
  assign multi_s   = is_mul_s | is_div_s;
  assign start_s   = accept_s & multi_s;

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign div0      = div0_q;

  alu_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk_i    (clk),
    .reset_i  (reset),
    .start_i  (start_s),
    .is_mul_i (is_mul_s),
    .a_i      (A),
    .b_i      (B),
    .done_o   (core_done_s),
    .lo_o     (core_lo_s),
    .hi_o     (core_hi_s)
  );

  // Single-cycle operation results; unlisted and reserved codes give zero.
  always_comb begin
    single_s = {WIDTH{1'b0}};
    case (alu_action)
      ACTION_BITS'(ACT_ADD):  single_s = A + B;
      ACTION_BITS'(ACT_SUB):  single_s = A - B;
      ACTION_BITS'(ACT_AND):  single_s = A & B;
      ACTION_BITS'(ACT_OR):   single_s = A | B;
      ACTION_BITS'(ACT_NOT):  single_s = ~A;
      ACTION_BITS'(ACT_NEG):  single_s = {WIDTH{1'b0}} - A;
      ACTION_BITS'(ACT_SHL):  single_s = {A[WIDTH-2:0], 1'b0};
      ACTION_BITS'(ACT_SHR):  single_s = {1'b0, A[WIDTH-1:1]};
      ACTION_BITS'(ACT_HIB):  single_s = {B[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      ACTION_BITS'(ACT_PASS): single_s = A;
      ACTION_BITS'(ACT_SRA):  single_s = {A[WIDTH-1], A[WIDTH-1:1]};
      default:                single_s = {WIDTH{1'b0}};
    endcase
  end

  // Handshake FSM; DONE accepts like IDLE so single-cycle ops stream back to back.
  always_comb begin
    state_d     = state_q;
    out_valid_d = 1'b0;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    div0_d      = div0_q;
    pend_div0_d = pend_div0_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept_s && multi_s) begin
          state_d     = ST_BUSY;
          pend_div0_d = is_div_s && (B == {WIDTH{1'b0}});
        end else if (accept_s) begin
          state_d     = ST_DONE;
          out_valid_d = 1'b1;
          result_d    = single_s;
          result_hi_d = {WIDTH{1'b0}};
          div0_d      = 1'b0;
        end else begin
          state_d     = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (core_done_s) begin
          state_d     = ST_DONE;
          out_valid_d = 1'b1;
          result_d    = core_lo_s;
          result_hi_d = core_hi_s;
          div0_d      = pend_div0_q;
        end else begin
          state_d     = ST_BUSY;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any op in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= {WIDTH{1'b0}};
      result_hi_q <= {WIDTH{1'b0}};
      div0_q      <= 1'b0;
      pend_div0_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      div0_q      <= div0_d;
      pend_div0_q <= pend_div0_d;
    end
  end

endmodule

// File: tb/tb_alu_iter.sv
// Scoreboard bench for alu_iter: directed cases plus random ops against an arithmetic model.
// Expectations for action 11 follow ALU_ITER_DIV_EN.
`timescale 1ns/1ps
module tb_alu_iter;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   alu_action = 4'd0;
  logic [W-1:0] A = 16'h0000;
  logic [W-1:0] B = 16'h0000;
  logic         out_valid;
  logic [W-1:0] result, result_hi;
  logic         div0;

  typedef struct {
    logic [W-1:0] r;
    logic [W-1:0] h;
    logic         d;
    int           cyc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   ready_at = 0;

  alu_iter dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_action (alu_action),
    .A          (A),
    .B          (B),
    .out_valid  (out_valid),
    .result     (result),
    .result_hi  (result_hi),
    .div0       (div0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: plain arithmetic on the operands; cyc is when out_valid must be seen.
  function automatic exp_t model(input int act, input logic [W-1:0] a, input logic [W-1:0] b, input int now);
    exp_t e;
    int   p;
    int   s;
    bit   multi;
    multi = 1'b0;
    e.r = 16'h0000;
    e.h = 16'h0000;
    e.d = 1'b0;
    case (act)
      0:  e.r = a + b;
      1:  e.r = a - b;
      2:  e.r = a & b;
      3:  e.r = a | b;
      4:  e.r = ~a;
      5:  e.r = 16'd0 - a;
      6:  e.r = a * 16'd2;
      7:  e.r = a / 16'd2;
      8:  e.r = b * 16'd256;
      9:  e.r = a;
      10: begin
        p = int'($signed(a)) * int'($signed(b));
        e.r = p[15:0];
        e.h = p[31:16];
        multi = 1'b1;
      end
`ifdef ALU_ITER_DIV_EN
      11: begin
        if (b == 16'h0000) begin
          e.r = 16'hFFFF;
          e.h = a;
          e.d = 1'b1;
        end else begin
          e.r = a / b;
          e.h = a % b;
        end
        multi = 1'b1;
      end
`endif
      12: begin
        s = int'($signed(a));
        e.r = 16'(s >>> 1);
      end
      default: e.r = 16'h0000;
    endcase
    e.cyc = now + 1 + (multi ? W : 0);
    return e;
  endfunction

  // Hold the request until the model says the block is free, checking in_ready meanwhile.
  task automatic issue(input int act, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    @(negedge clk);
    in_valid   = 1'b1;
    alu_action = 4'(act);
    A          = a;
    B          = b;
    while (cyc < ready_at) begin
      check("in_ready_busy", {15'd0, in_ready}, 16'h0000);
      @(negedge clk);
    end
    check("in_ready_free", {15'd0, in_ready}, 16'h0001);
    e = model(act, a, b, cyc);
    sb_q.push_back(e);
    ready_at = e.cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid   = 1'b0;
      alu_action = 4'($urandom_range(15, 0));
      A          = W'($urandom);
      B          = W'($urandom);
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(7, 0))
      0:       return 16'h0000;
      1:       return 16'h0001;
      2:       return 16'h7FFF;
      3:       return 16'h8000;
      4:       return 16'hFFFF;
      default: return W'($urandom);
    endcase
  endfunction

  // Monitor: every out_valid pulse must match the oldest expectation, on the expected cycle.
  always @(negedge clk) begin
    if (!reset && out_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_out_valid: got result 0x%0h with no request pending (cycle %0d)", result, cyc);
      end else begin
        mon_e = sb_q.pop_front();
        check("result", result, mon_e.r);
        check("result_hi", result_hi, mon_e.h);
        check("div0", {15'd0, div0}, {15'd0, mon_e.d});
        check_int("out_valid_cycle", cyc, mon_e.cyc);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int guard;
    repeat (3) @(negedge clk);
    check("reset_out_valid", {15'd0, out_valid}, 16'h0000);
    check("reset_result", result, 16'h0000);
    check("reset_result_hi", result_hi, 16'h0000);
    check("reset_div0", {15'd0, div0}, 16'h0000);
    check("reset_in_ready", {15'd0, in_ready}, 16'h0001);
    reset    = 1'b0;
    ready_at = cyc;

    issue(0, 16'h7FFF, 16'h0001);
    issue(1, 16'h0000, 16'h0001);
    issue(8, 16'h1234, 16'h00AB);
    idle(2);

    issue(10, 16'hFFFD, 16'h0007);
    issue(0, 16'h1111, 16'h2222);
    idle(3);

    issue(11, 16'd100, 16'd7);
    issue(11, 16'h1234, 16'h0000);
    issue(11, 16'hFFFF, 16'h0001);
    issue(10, 16'h8000, 16'h8000);
    idle(2);

    issue(10, 16'h1234, 16'h5678);
    idle(4);
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b0;
    sb_q.delete();
    @(negedge clk);
    reset = 1'b0;
    check("midop_reset_out_valid", {15'd0, out_valid}, 16'h0000);
    check("midop_reset_result", result, 16'h0000);
    check("midop_reset_result_hi", result_hi, 16'h0000);
    check("midop_reset_in_ready", {15'd0, in_ready}, 16'h0001);
    ready_at = cyc;
    issue(11, 16'd100, 16'd7);
    idle(1);

    for (int i = 0; i < 200; i++) begin
      issue($urandom_range(15, 0), pick(), pick());
      if ($urandom_range(3, 0) == 0) idle($urandom_range(2, 1));
    end
    idle(1);

    guard = 0;
    while (sb_q.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check_int("scoreboard_drained", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
